// File: rtl/matmul_sched_pkg.sv
// Shared types for the tiled GEMM scheduler.
// State encoding and tile coordinate bundle.
package matmul_sched_pkg;

  localparam int unsigned TILE_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DONE
  } state_e;

  typedef logic [TILE_W_DEF-1:0] tile_idx_t;

  typedef struct packed {
    tile_idx_t m;
    tile_idx_t n;
    tile_idx_t k;
  } tile_coord_t;

endpackage

// File: rtl/matmul_tile_scheduler_counter.sv
// Nested k/n/m tile index counters.
// k is innermost; n wraps into m.
module tile_index_counter
  import matmul_sched_pkg::*;
#(
  parameter int unsigned TILE_W = TILE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              step_k_i,
  input  logic              step_mn_i,
  input  logic              reset_k_i,
  input  logic [TILE_W-1:0] m_tiles_i,
  input  logic [TILE_W-1:0] n_tiles_i,
  input  logic [TILE_W-1:0] k_tiles_i,
  output logic [TILE_W-1:0] m_o,
  output logic [TILE_W-1:0] n_o,
  output logic [TILE_W-1:0] k_o,
  output logic              last_k_o,
  output logic              last_tile_o
);

  logic [TILE_W-1:0] m_q, m_d;
  logic [TILE_W-1:0] n_q, n_d;
  logic [TILE_W-1:0] k_q, k_d;
  logic              last_n;
  logic              last_m;

  assign last_k_o    = (k_q == k_tiles_i - TILE_W'(1));
  assign last_n      = (n_q == n_tiles_i - TILE_W'(1));
  assign last_m      = (m_q == m_tiles_i - TILE_W'(1));
  assign last_tile_o = last_n && last_m;

  assign m_o = m_q;
  assign n_o = n_q;
  assign k_o = k_q;

  always_comb begin
    m_d = m_q;
    n_d = n_q;
    k_d = k_q;
    if (clear_i) begin
      m_d = '0;
      n_d = '0;
      k_d = '0;
    end else begin
      if (step_k_i) k_d = k_q + TILE_W'(1);
      if (reset_k_i) k_d = '0;
      if (step_mn_i) begin
        if (last_n) begin
          n_d = '0;
          m_d = m_q + TILE_W'(1);
        end else begin
          n_d = n_q + TILE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q <= '0;
      n_q <= '0;
      k_q <= '0;
    end else begin
      m_q <= m_d;
      n_q <= n_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Tiled GEMM sequencer around one MAC array.
// acc_q holds bias/zero before k=0 and the partial sum after.
module matmul_tile_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int unsigned M      = 2,
  parameter int unsigned N      = 2,
  parameter int unsigned P      = 8,
  parameter int unsigned TILE_W = TILE_W_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                start_i,
  input  logic [TILE_W-1:0]                   cfg_m_tiles_i,
  input  logic [TILE_W-1:0]                   cfg_n_tiles_i,
  input  logic [TILE_W-1:0]                   cfg_k_tiles_i,
  input  logic                                bias_en_i,
  input  logic signed [M-1:0][N-1:0][4*P-1:0] bias_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                req_valid_o,
  input  logic                                req_ready_i,
  output logic [TILE_W-1:0]                   req_m_o,
  output logic [TILE_W-1:0]                   req_n_o,
  output logic [TILE_W-1:0]                   req_k_o,
  input  logic                                opnd_valid_i,
  output logic                                opnd_ready_o,
  output logic                                mac_valid_o,
  input  logic                                mac_ready_i,
  output logic signed [M-1:0][N-1:0][4*P-1:0] mac_c_o,
  input  logic                                mac_valid_i,
  output logic                                mac_ready_o,
  input  logic signed [M-1:0][N-1:0][4*P-1:0] mac_d_i,
  output logic                                wb_valid_o,
  input  logic                                wb_ready_i,
  output logic [TILE_W-1:0]                   wb_m_o,
  output logic [TILE_W-1:0]                   wb_n_o,
  output logic signed [M-1:0][N-1:0][4*P-1:0] wb_data_o
);

  state_e state_q, state_d;

  logic signed [M-1:0][N-1:0][4*P-1:0] acc_q, acc_d;

  logic [TILE_W-1:0] cfg_m_q, cfg_m_d;
  logic [TILE_W-1:0] cfg_n_q, cfg_n_d;
  logic [TILE_W-1:0] cfg_k_q, cfg_k_d;
  logic              bias_en_q, bias_en_d;

  logic              clear, step_k, step_mn, reset_k;
  logic [TILE_W-1:0] idx_m, idx_n, idx_k;
  logic              last_k, last_tile;
  logic              cfg_zero;

  tile_index_counter #(
    .TILE_W (TILE_W)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear),
    .step_k_i    (step_k),
    .step_mn_i   (step_mn),
    .reset_k_i   (reset_k),
    .m_tiles_i   (cfg_m_q),
    .n_tiles_i   (cfg_n_q),
    .k_tiles_i   (cfg_k_q),
    .m_o         (idx_m),
    .n_o         (idx_n),
    .k_o         (idx_k),
    .last_k_o    (last_k),
    .last_tile_o (last_tile)
  );

  assign cfg_zero = (cfg_m_q == '0) || (cfg_n_q == '0)
                 || (cfg_k_q == '0);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cfg_m_d      = cfg_m_q;
    cfg_n_d      = cfg_n_q;
    cfg_k_d      = cfg_k_q;
    bias_en_d    = bias_en_q;
    clear        = 1'b0;
    step_k       = 1'b0;
    step_mn      = 1'b0;
    reset_k      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    req_valid_o  = 1'b0;
    req_m_o      = '0;
    req_n_o      = '0;
    req_k_o      = '0;
    opnd_ready_o = 1'b0;
    mac_valid_o  = 1'b0;
    mac_c_o      = '0;
    mac_ready_o  = 1'b0;
    wb_valid_o   = 1'b0;
    wb_m_o       = '0;
    wb_n_o       = '0;
    wb_data_o    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cfg_m_d   = cfg_m_tiles_i;
          cfg_n_d   = cfg_n_tiles_i;
          cfg_k_d   = cfg_k_tiles_i;
          bias_en_d = bias_en_i;
          clear     = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        busy_o = 1'b1;
        if (cfg_zero) begin
          state_d = S_DONE;
        end else begin
          req_valid_o = 1'b1;
          req_m_o     = idx_m;
          req_n_o     = idx_n;
          req_k_o     = idx_k;
          if (req_ready_i) begin
            state_d = S_ISSUE;
            // Preload C for the first k-tile so it is frozen through ISSUE
            if (idx_k == '0) acc_d = bias_en_q ? bias_i : '0;
          end
        end
      end
      S_ISSUE: begin
        busy_o       = 1'b1;
        mac_valid_o  = opnd_valid_i;
        opnd_ready_o = mac_ready_i;
        mac_c_o      = acc_q;
        if (opnd_valid_i && mac_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        busy_o      = 1'b1;
        mac_ready_o = 1'b1;
        if (mac_valid_i) begin
          acc_d = mac_d_i;
          if (last_k) begin
            state_d = S_WB;
          end else begin
            step_k  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_WB: begin
        busy_o     = 1'b1;
        wb_valid_o = 1'b1;
        wb_m_o     = idx_m;
        wb_n_o     = idx_n;
        wb_data_o  = acc_q;
        if (wb_ready_i) begin
          step_mn = 1'b1;
          reset_k = 1'b1;
          state_d = last_tile ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cfg_m_q   <= '0;
      cfg_n_q   <= '0;
      cfg_k_q   <= '0;
      bias_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cfg_m_q   <= cfg_m_d;
      cfg_n_q   <= cfg_n_d;
      cfg_k_q   <= cfg_k_d;
      bias_en_q <= bias_en_d;
    end
  end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Scoreboard bench for matmul_tile_scheduler.
// Models fetch, a C+delta MAC array and the writer.
module tb_matmul_tile_scheduler;
  import matmul_sched_pkg::*;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int P  = 8;
  localparam int TW = 8;
  localparam int DW = 4 * P;

  typedef logic signed [M-1:0][N-1:0][DW-1:0] tile_t;
  typedef struct packed {
    logic [TW-1:0] m;
    logic [TW-1:0] n;
    tile_t         d;
  } wb_t;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [TW-1:0] cfg_m_tiles_i, cfg_n_tiles_i, cfg_k_tiles_i;
  logic          bias_en_i;
  tile_t         bias_i;
  logic          busy_o, done_o;
  logic          req_valid_o, req_ready_i;
  logic [TW-1:0] req_m_o, req_n_o, req_k_o;
  logic          opnd_valid_i, opnd_ready_o;
  logic          mac_valid_o, mac_ready_i;
  tile_t         mac_c_o;
  logic          mac_valid_i, mac_ready_o;
  tile_t         mac_d_i;
  logic          wb_valid_o, wb_ready_i;
  logic [TW-1:0] wb_m_o, wb_n_o;
  tile_t         wb_data_o;

  always #5 clk = ~clk;

  matmul_tile_scheduler #(
    .M(M), .N(N), .P(P), .TILE_W(TW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .cfg_m_tiles_i (cfg_m_tiles_i),
    .cfg_n_tiles_i (cfg_n_tiles_i),
    .cfg_k_tiles_i (cfg_k_tiles_i),
    .bias_en_i     (bias_en_i),
    .bias_i        (bias_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_m_o       (req_m_o),
    .req_n_o       (req_n_o),
    .req_k_o       (req_k_o),
    .opnd_valid_i  (opnd_valid_i),
    .opnd_ready_o  (opnd_ready_o),
    .mac_valid_o   (mac_valid_o),
    .mac_ready_i   (mac_ready_i),
    .mac_c_o       (mac_c_o),
    .mac_valid_i   (mac_valid_i),
    .mac_ready_o   (mac_ready_o),
    .mac_d_i       (mac_d_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_m_o        (wb_m_o),
    .wb_n_o        (wb_n_o),
    .wb_data_o     (wb_data_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [3*TW-1:0] req_q[$];
  wb_t             wb_q[$];

  int    cm, cn, ck, add_base, lat_max;
  bit    cben, rnd_add, stall;
  tile_t cbias;

  bit    opnd_pend, arr_busy;
  int    arr_cnt, done_cnt;
  int    cur_m, cur_n, cur_k;
  tile_t arr_d, last_d;

  bit              p_req_stall, p_mac_stall, p_wb_stall, p_last_wb;
  logic [3*TW-1:0] p_req;
  tile_t           p_c;
  wb_t             p_wb;

  function automatic tile_t addv(int m, int n, int k);
    tile_t r;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        r[i][j] = DW'(add_base +
                  (rnd_add ? m*16 + n*4 + k + i*2 + j : 0));
    return r;
  endfunction

  function automatic tile_t tile_add(tile_t a, tile_t b);
    tile_t r;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        r[i][j] = a[i][j] + b[i][j];
    return r;
  endfunction

  // Fetch, array and writer models plus scoreboard checks.
  initial begin : model
    forever begin
      @(negedge clk);
      req_ready_i  = !stall || ($urandom_range(0, 2) == 0);
      mac_ready_i  = !stall || ($urandom_range(0, 2) == 0);
      wb_ready_i   = !stall || ($urandom_range(0, 2) == 0);
      opnd_valid_i = opnd_pend;
      mac_valid_i  = arr_busy && (arr_cnt == 0);
      mac_d_i      = arr_busy ? arr_d : '0;
      #1;
      if (!rst_ni) begin
        p_req_stall = 0;
        p_mac_stall = 0;
        p_wb_stall  = 0;
        p_last_wb   = 0;
      end else begin
        if (p_req_stall)
          chk("req_hold", {req_valid_o, req_m_o, req_n_o, req_k_o},
              {1'b1, p_req});
        if (p_mac_stall) begin
          chk("mac_valid_hold", mac_valid_o, 1'b1);
          chk("mac_c_hold", mac_c_o, p_c);
        end
        if (p_wb_stall) begin
          chk("wb_idx_hold", {wb_valid_o, wb_m_o, wb_n_o},
              {1'b1, p_wb.m, p_wb.n});
          chk("wb_data_hold", wb_data_o, p_wb.d);
        end
        if (p_last_wb) chk("done_after_wb", done_o, 1'b1);
        if (done_o) begin
          done_cnt++;
          chk("busy_at_done", busy_o, 1'b0);
        end
        p_last_wb = 0;
        if (req_valid_o && req_ready_i) begin
          if (req_q.size() == 0) begin
            chk("req_extra", {req_m_o, req_n_o, req_k_o}, '1);
          end else begin
            chk("req_idx", {req_m_o, req_n_o, req_k_o},
                req_q.pop_front());
          end
          cur_m     = int'(req_m_o);
          cur_n     = int'(req_n_o);
          cur_k     = int'(req_k_o);
          opnd_pend = 1;
        end
        if (mac_valid_i && mac_ready_o) begin
          arr_busy = 0;
          last_d   = arr_d;
        end
        if (mac_valid_o && mac_ready_i) begin
          chk("mac_c", mac_c_o,
              (cur_k == 0) ? (cben ? cbias : '0) : last_d);
          arr_d     = tile_add(mac_c_o, addv(cur_m, cur_n, cur_k));
          arr_busy  = 1;
          arr_cnt   = $urandom_range(0, lat_max);
          opnd_pend = 0;
        end else if (arr_busy && arr_cnt > 0) begin
          arr_cnt--;
        end
        if (wb_valid_o && wb_ready_i) begin
          if (wb_q.size() == 0) begin
            chk("wb_extra", {wb_m_o, wb_n_o}, '1);
          end else begin
            wb_t e;
            e = wb_q.pop_front();
            chk("wb_mn", {wb_m_o, wb_n_o}, {e.m, e.n});
            chk("wb_data", wb_data_o, e.d);
            p_last_wb = (wb_q.size() == 0);
          end
        end
        p_req_stall = req_valid_o && !req_ready_i;
        p_req       = {req_m_o, req_n_o, req_k_o};
        p_mac_stall = mac_valid_o && !mac_ready_i;
        p_c         = mac_c_o;
        p_wb_stall  = wb_valid_o && !wb_ready_i;
        p_wb        = '{m: wb_m_o, n: wb_n_o, d: wb_data_o};
      end
    end
  end

  task automatic launch(input int m, input int n, input int k,
                        input bit ben, input bit rb,
                        input int bval, input int ab,
                        input bit rnd, input bit stl,
                        input int lat);
    tile_t acc;
    cm = m; cn = n; ck = k;
    cben = ben; add_base = ab; rnd_add = rnd;
    stall = stl; lat_max = lat;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        cbias[i][j] = rb ? DW'($urandom) : DW'(bval);
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++) begin
        acc = ben ? cbias : '0;
        for (int ki = 0; ki < k; ki++) begin
          req_q.push_back({TW'(mi), TW'(ni), TW'(ki)});
          acc = tile_add(acc, addv(mi, ni, ki));
        end
        if (k > 0) wb_q.push_back('{m: TW'(mi), n: TW'(ni), d: acc});
      end
    done_cnt = 0;
    @(negedge clk);
    start_i       = 1'b1;
    cfg_m_tiles_i = TW'(m);
    cfg_n_tiles_i = TW'(n);
    cfg_k_tiles_i = TW'(k);
    bias_en_i     = ben;
    bias_i        = cbias;
    @(negedge clk);
    start_i = 1'b0;
    #2;
    chk("busy_after_start", busy_o, 1'b1);
  endtask

  task automatic run(input int m, input int n, input int k,
                     input bit ben, input bit rb,
                     input int bval, input int ab,
                     input bit rnd, input bit stl,
                     input int lat, input bit dbl);
    launch(m, n, k, ben, rb, bval, ab, rnd, stl, lat);
    if (m == 0 || n == 0 || k == 0) begin
      chk("zero_done_early", done_o, 1'b0);
      chk("zero_no_req", req_valid_o, 1'b0);
      @(negedge clk);
      #2;
      chk("zero_done", done_o, 1'b1);
      chk("zero_busy", busy_o, 1'b0);
    end
    if (dbl) begin
      @(negedge clk);
      start_i       = 1'b1;
      cfg_m_tiles_i = 1;
      cfg_n_tiles_i = 1;
      cfg_k_tiles_i = 1;
      @(negedge clk);
      start_i = 1'b0;
    end
    for (int c = 0; c < 5000 && done_cnt == 0; c++) @(negedge clk);
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    #2;
    chk("done_count", done_cnt, 1);
    chk("busy_idle", busy_o, 1'b0);
    chk("req_left", req_q.size(), 0);
    chk("wb_left", wb_q.size(), 0);
  endtask

  initial begin : stim
    bit hit;
    rst_ni        = 1'b0;
    start_i       = 1'b0;
    cfg_m_tiles_i = '0;
    cfg_n_tiles_i = '0;
    cfg_k_tiles_i = '0;
    bias_en_i     = 1'b0;
    bias_i        = '0;
    req_ready_i   = 1'b0;
    opnd_valid_i  = 1'b0;
    mac_ready_i   = 1'b0;
    mac_valid_i   = 1'b0;
    mac_d_i       = '0;
    wb_ready_i    = 1'b0;
    stall         = 0;
    lat_max       = 0;
    #12;
    chk("rst_ctrl", {busy_o, done_o, req_valid_o, opnd_ready_o,
                     mac_valid_o, mac_ready_o, wb_valid_o}, '0);
    chk("rst_idx", {req_m_o, req_n_o, req_k_o, wb_m_o, wb_n_o}, '0);
    chk("rst_c", mac_c_o, '0);
    chk("rst_wb", wb_data_o, '0);
    #11 rst_ni = 1'b1;

    run(1, 1, 1, 1, 0, 5, 7, 0, 0, 0, 0);
    run(1, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    run(2, 2, 1, 1, 1, 0, 3, 1, 0, 1, 0);
    run(2, 3, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    run(3, 2, 3, 1, 1, 0, 9, 1, 1, 5, 1);
    run(2, 2, 2, 0, 1, 0, -2, 1, 1, 3, 0);

    launch(1, 1, 2, 0, 0, 0, 1, 0, 0, 4);
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      #2;
      hit = mac_ready_o && (cur_k == 1);
    end
    chk("reached_wait_k1", hit, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("abort_ctrl", {busy_o, done_o, req_valid_o, opnd_ready_o,
                       mac_valid_o, mac_ready_o, wb_valid_o}, '0);
    chk("abort_c", mac_c_o, '0);
    req_q.delete();
    wb_q.delete();
    opnd_pend = 0;
    arr_busy  = 0;
    repeat (2) @(negedge clk);
    #3 rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    chk("abort_no_done", done_cnt, 0);
    run(1, 1, 2, 1, 1, 0, 4, 1, 1, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
